// File: rtl/aximm_csr_slave.sv
// ---------------------------------------------------------------------------
// aximm_csr_slave
//
// CSR responder on the host control bus of the AXI-MM-over-AIB test harness.
// Host accesses are decoded into configuration, delay, status and
// data-capture registers. Writing the go bit of WR_CFG / RD_CFG issues a
// single-cycle start pulse to the matching traffic generator.
//
// Ports
//   avmm_clk, avmm_rst_n      : clock, asynchronous active-low reset
//   i_wren, i_rden            : level requests; one access per 0->1 edge
//   i_wr_addr, i_wrdata       : byte address (reads and writes), write data
//   o_master_readdata         : read data, held until the next response
//   o_master_readdatavalid    : one-cycle pulse qualifying readdata
//   o_master_waitrequest      : high while a read is in flight
//   i_link_sts                : asynchronous link-online flags (synchronised)
//   i_chk_sts                 : checker flags {align[1:0], done, pass}
//   i_wr_done, i_rd_done      : generator completion pulses (set stickies)
//   i_dout_*/i_din_*          : 64-bit captured beats, readable as 2 words
//   o_wr_cfg, o_rd_cfg        : config registers (bit 2 always 0)
//   o_mm_addr, o_dly_x/y/z    : register contents
//   o_wr_go, o_rd_go          : one-cycle start pulses
//   o_rd_state                : current read FSM state (debug)
// ---------------------------------------------------------------------------
module aximm_csr_slave #(
    parameter logic [15:0] BASE_HI   = 16'h5000,
    parameter logic [31:0] DLY_X_RST = 32'h0,
    parameter logic [31:0] DLY_Y_RST = 32'h0,
    parameter logic [31:0] DLY_Z_RST = 32'h0
) (
    input  logic        avmm_clk,
    input  logic        avmm_rst_n,
    input  logic        i_wren,
    input  logic        i_rden,
    input  logic [31:0] i_wr_addr,
    input  logic [31:0] i_wrdata,
    output logic [31:0] o_master_readdata,
    output logic        o_master_readdatavalid,
    output logic        o_master_waitrequest,
    input  logic [3:0]  i_link_sts,
    input  logic [3:0]  i_chk_sts,
    input  logic        i_wr_done,
    input  logic        i_rd_done,
    input  logic [63:0] i_dout_first,
    input  logic [63:0] i_dout_last,
    input  logic [63:0] i_din_first,
    input  logic [63:0] i_din_last,
    output logic [31:0] o_wr_cfg,
    output logic [31:0] o_rd_cfg,
    output logic [31:0] o_mm_addr,
    output logic        o_wr_go,
    output logic        o_rd_go,
    output logic [31:0] o_dly_x,
    output logic [31:0] o_dly_y,
    output logic [31:0] o_dly_z,
    output logic [1:0]  o_rd_state
);

    localparam logic [15:0] OFF_WR_CFG   = 16'h1000;
    localparam logic [15:0] OFF_MM_ADDR  = 16'h1004;
    localparam logic [15:0] OFF_BUS_STS  = 16'h1008;
    localparam logic [15:0] OFF_LINK_STS = 16'h100C;
    localparam logic [15:0] OFF_RD_CFG   = 16'h1010;
    localparam logic [15:0] OFF_DLY_X    = 16'h2000;
    localparam logic [15:0] OFF_DLY_Y    = 16'h2004;
    localparam logic [15:0] OFF_DLY_Z    = 16'h2008;
    localparam logic [15:0] OFF_DOF_LO   = 16'h4000;
    localparam logic [15:0] OFF_DOF_HI   = 16'h4004;
    localparam logic [15:0] OFF_DOL_LO   = 16'h4010;
    localparam logic [15:0] OFF_DOL_HI   = 16'h4014;
    localparam logic [15:0] OFF_DIF_LO   = 16'h4020;
    localparam logic [15:0] OFF_DIF_HI   = 16'h4024;
    localparam logic [15:0] OFF_DIL_LO   = 16'h4030;
    localparam logic [15:0] OFF_DIL_HI   = 16'h4034;

    // Go bit is a trigger, never stored.
    localparam logic [31:0] CFG_MASK = 32'hFFFF_FFFB;

    // Bus protocol: a request is a 0->1 edge of i_wren / i_rden, sampled
    // against a registered copy. A write completes without handshake. A read
    // accepted in IDLE raises waitrequest for two cycles; the cycle after
    // waitrequest falls, readdatavalid pulses once with readdata. Read edges
    // seen while waitrequest is high, or together with a write edge, are
    // dropped and never answered.

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_DECODE = 2'd1,
        RD_RESP   = 2'd2
    } rd_state_t;

    rd_state_t   state_q, state_d;

    logic        wren_q, rden_q;
    logic        wr_edge, rd_edge;
    logic        wr_pend;
    logic [31:0] wr_addr_q, wr_data_q;
    logic        wr_hit;
    logic [15:0] wr_off;
    logic        wr_go_d, rd_go_d;

    logic [31:0] wr_cfg_q, rd_cfg_q, mm_addr_q;
    logic [31:0] dly_x_q, dly_y_q, dly_z_q;
    logic        wr_done_q, rd_done_q;
    logic [3:0]  link_s1_q, link_s2_q;

    logic [31:0] rd_addr_q;
    logic [31:0] rd_mux;
    logic [31:0] rdata_q;
    logic        rd_accept, rdata_load, resp_fire;

    assign wr_edge = i_wren & ~wren_q;
    // A simultaneous write edge wins; the read is discarded.
    assign rd_edge = i_rden & ~rden_q & ~wr_edge;

    // Request edge detection and write capture. The write is staged one
    // cycle so that address decode works from stable registered values.
    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
            wr_pend   <= 1'b0;
            wr_addr_q <= 32'h0;
            wr_data_q <= 32'h0;
        end else begin
            wren_q  <= i_wren;
            rden_q  <= i_rden;
            wr_pend <= wr_edge;
            if (wr_edge) begin
                wr_addr_q <= i_wr_addr;
                wr_data_q <= i_wrdata;
            end
        end
    end

    assign wr_hit  = wr_pend && (wr_addr_q[31:16] == BASE_HI);
    assign wr_off  = wr_addr_q[15:0];
    assign wr_go_d = wr_hit && (wr_off == OFF_WR_CFG) && wr_data_q[2];
    assign rd_go_d = wr_hit && (wr_off == OFF_RD_CFG) && wr_data_q[2];

    // RW registers. Read-only and unmapped offsets fall to default.
    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            wr_cfg_q  <= 32'h0;
            rd_cfg_q  <= 32'h0;
            mm_addr_q <= 32'h0;
            dly_x_q   <= DLY_X_RST;
            dly_y_q   <= DLY_Y_RST;
            dly_z_q   <= DLY_Z_RST;
        end else if (wr_hit) begin
            case (wr_off)
                OFF_WR_CFG:  wr_cfg_q  <= wr_data_q & CFG_MASK;
                OFF_RD_CFG:  rd_cfg_q  <= wr_data_q & CFG_MASK;
                OFF_MM_ADDR: mm_addr_q <= wr_data_q;
                OFF_DLY_X:   dly_x_q   <= wr_data_q;
                OFF_DLY_Y:   dly_y_q   <= wr_data_q;
                OFF_DLY_Z:   dly_z_q   <= wr_data_q;
                default:     ;
            endcase
        end
    end

    // Start pulses and completion stickies. A completion pulse arriving in
    // the same cycle as the clearing go-write leaves the sticky set.
    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            o_wr_go   <= 1'b0;
            o_rd_go   <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            o_wr_go <= wr_go_d;
            o_rd_go <= rd_go_d;
            if (i_wr_done)    wr_done_q <= 1'b1;
            else if (wr_go_d) wr_done_q <= 1'b0;
            if (i_rd_done)    rd_done_q <= 1'b1;
            else if (rd_go_d) rd_done_q <= 1'b0;
        end
    end

    // Two-flop synchroniser for the asynchronous link flags.
    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            link_s1_q <= 4'h0;
            link_s2_q <= 4'h0;
        end else begin
            link_s1_q <= i_link_sts;
            link_s2_q <= link_s1_q;
        end
    end

    // Read mux, driven by the address latched when the read was accepted.
    always_comb begin
        rd_mux = 32'h0;
        if (rd_addr_q[31:16] == BASE_HI) begin
            case (rd_addr_q[15:0])
                OFF_WR_CFG:   rd_mux = wr_cfg_q;
                OFF_MM_ADDR:  rd_mux = mm_addr_q;
                OFF_BUS_STS:  rd_mux = {26'h0, rd_done_q, wr_done_q, i_chk_sts};
                OFF_LINK_STS: rd_mux = {28'h0, link_s2_q};
                OFF_RD_CFG:   rd_mux = rd_cfg_q;
                OFF_DLY_X:    rd_mux = dly_x_q;
                OFF_DLY_Y:    rd_mux = dly_y_q;
                OFF_DLY_Z:    rd_mux = dly_z_q;
                OFF_DOF_LO:   rd_mux = i_dout_first[31:0];
                OFF_DOF_HI:   rd_mux = i_dout_first[63:32];
                OFF_DOL_LO:   rd_mux = i_dout_last[31:0];
                OFF_DOL_HI:   rd_mux = i_dout_last[63:32];
                OFF_DIF_LO:   rd_mux = i_din_first[31:0];
                OFF_DIF_HI:   rd_mux = i_din_first[63:32];
                OFF_DIL_LO:   rd_mux = i_din_last[31:0];
                OFF_DIL_HI:   rd_mux = i_din_last[63:32];
                default:      rd_mux = 32'h0;
            endcase
        end
    end

    // Read FSM: state register.
    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) state_q <= RD_IDLE;
        else             state_q <= state_d;
    end

    // Read FSM: next state and control strobes.
    always_comb begin
        state_d              = state_q;
        rd_accept            = 1'b0;
        rdata_load           = 1'b0;
        resp_fire            = 1'b0;
        o_master_waitrequest = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (rd_edge) begin
                    rd_accept = 1'b1;
                    state_d   = RD_DECODE;
                end
            end
            RD_DECODE: begin
                o_master_waitrequest = 1'b1;
                rdata_load           = 1'b1;
                state_d              = RD_RESP;
            end
            RD_RESP: begin
                o_master_waitrequest = 1'b1;
                resp_fire            = 1'b1;
                state_d              = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Read datapath. readdata/readdatavalid are registered so the response
    // appears the cycle after waitrequest falls.
    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            rd_addr_q              <= 32'h0;
            rdata_q                <= 32'h0;
            o_master_readdata      <= 32'h0;
            o_master_readdatavalid <= 1'b0;
        end else begin
            if (rd_accept)  rd_addr_q <= i_wr_addr;
            if (rdata_load) rdata_q   <= rd_mux;
            if (resp_fire)  o_master_readdata <= rdata_q;
            o_master_readdatavalid <= resp_fire;
        end
    end

    assign o_wr_cfg   = wr_cfg_q;
    assign o_rd_cfg   = rd_cfg_q;
    assign o_mm_addr  = mm_addr_q;
    assign o_dly_x    = dly_x_q;
    assign o_dly_y    = dly_y_q;
    assign o_dly_z    = dly_z_q;
    assign o_rd_state = state_q;

endmodule

// File: tb/tb_aximm_csr_slave.sv
// Testbench for aximm_csr_slave: directed register/collision scenarios
// followed by randomized accesses checked against a register-map model.
module tb_aximm_csr_slave;

  localparam logic [31:0] DX = 32'h0000_0000;
  localparam logic [31:0] DY = 32'hA5A5_0001;
  localparam logic [31:0] DZ = 32'h0000_1770;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wren = 1'b0, rden = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, waitreq;
  logic [3:0]  link_sts = '0, chk_sts = '0;
  logic        wr_done = 1'b0, rd_done = 1'b0;
  logic [63:0] dout_first = '0, dout_last = '0, din_first = '0, din_last = '0;
  logic [31:0] wr_cfg, rd_cfg, mm_addr, dly_x, dly_y, dly_z;
  logic        wr_go, rd_go;
  logic [1:0]  rd_state;

  aximm_csr_slave #(
    .BASE_HI(16'h5000), .DLY_X_RST(DX), .DLY_Y_RST(DY), .DLY_Z_RST(DZ)
  ) dut (
    .avmm_clk(clk), .avmm_rst_n(rst_n),
    .i_wren(wren), .i_rden(rden), .i_wr_addr(addr), .i_wrdata(wdata),
    .o_master_readdata(rdata), .o_master_readdatavalid(rvalid),
    .o_master_waitrequest(waitreq),
    .i_link_sts(link_sts), .i_chk_sts(chk_sts),
    .i_wr_done(wr_done), .i_rd_done(rd_done),
    .i_dout_first(dout_first), .i_dout_last(dout_last),
    .i_din_first(din_first), .i_din_last(din_last),
    .o_wr_cfg(wr_cfg), .o_rd_cfg(rd_cfg), .o_mm_addr(mm_addr),
    .o_wr_go(wr_go), .o_rd_go(rd_go),
    .o_dly_x(dly_x), .o_dly_y(dly_y), .o_dly_z(dly_z),
    .o_rd_state(rd_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;

  always @(negedge clk) if (rvalid) valid_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_rw [logic [15:0]];
  logic        m_wr_done, m_rd_done;
  logic [31:0] exp_q[$];

  function automatic void model_reset();
    m_rw[16'h1000] = 32'h0;
    m_rw[16'h1004] = 32'h0;
    m_rw[16'h1010] = 32'h0;
    m_rw[16'h2000] = DX;
    m_rw[16'h2004] = DY;
    m_rw[16'h2008] = DZ;
    m_wr_done = 1'b0;
    m_rd_done = 1'b0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    logic [15:0] off;
    off = a[15:0];
    if (a[31:16] != 16'h5000 || !m_rw.exists(off)) return;
    if (off == 16'h1000 || off == 16'h1010) begin
      m_rw[off] = {d[31:3], 1'b0, d[1:0]};
      if (d[2] && off == 16'h1000) m_wr_done = 1'b0;
      if (d[2] && off == 16'h1010) m_rd_done = 1'b0;
    end else begin
      m_rw[off] = d;
    end
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [15:0] off;
    off = a[15:0];
    if (a[31:16] != 16'h5000) return 32'h0;
    if (m_rw.exists(off)) return m_rw[off];
    case (off)
      16'h1008: return {26'h0, m_rd_done, m_wr_done, chk_sts};
      16'h100C: return {28'h0, link_sts};
      16'h4000: return dout_first[31:0];
      16'h4004: return dout_first[63:32];
      16'h4010: return dout_last[31:0];
      16'h4014: return dout_last[63:32];
      16'h4020: return din_first[31:0];
      16'h4024: return din_first[63:32];
      16'h4030: return din_last[31:0];
      16'h4034: return din_last[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_regs(input string tag);
    check({tag, ".wr_cfg"},  wr_cfg,  m_rw[16'h1000]);
    check({tag, ".rd_cfg"},  rd_cfg,  m_rw[16'h1010]);
    check({tag, ".mm_addr"}, mm_addr, m_rw[16'h1004]);
    check({tag, ".dly_x"},   dly_x,   m_rw[16'h2000]);
    check({tag, ".dly_y"},   dly_y,   m_rw[16'h2004]);
    check({tag, ".dly_z"},   dly_z,   m_rw[16'h2008]);
  endtask

  task automatic apply_reset();
    wren = 1'b0; rden = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  // Write with wren held for 'hold' cycles; optionally pulse i_wr_done in
  // the cycle the write takes effect.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input int hold, input bit done_at_exec);
    logic exp_wgo, exp_rgo;
    int   last;
    exp_wgo = (a == 32'h5000_1000) && d[2];
    exp_rgo = (a == 32'h5000_1010) && d[2];
    last = ((hold > 3) ? hold : 3) + 1;
    addr = a; wdata = d; wren = 1'b1;
    for (int k = 1; k <= last; k++) begin
      tick();
      if (k >= hold) wren = 1'b0;
      if (k == 1) begin
        if (done_at_exec) wr_done = 1'b1;
        check("wr_go_early", wr_go, 1'b0);
      end
      if (k == 2) begin
        wr_done = 1'b0;
        model_write(a, d);
        if (done_at_exec) m_wr_done = 1'b1;
        check("wr_go_pulse", wr_go, exp_wgo);
        check("rd_go_pulse", rd_go, exp_rgo);
        check_regs("wr");
      end
      if (k >= 3) begin
        check("wr_go_once", wr_go, 1'b0);
        check("rd_go_once", rd_go, 1'b0);
      end
    end
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [31:0] e, got_exp;
    e = exp_read(a);
    exp_q.push_back(e);
    addr = a; rden = 1'b1;
    tick();
    rden = 1'b0;
    check("rd_wait_e1", waitreq, 1'b1);
    check("rd_valid_e1", rvalid, 1'b0);
    tick();
    check("rd_wait_e2", waitreq, 1'b1);
    check("rd_valid_e2", rvalid, 1'b0);
    tick();
    check("rd_valid_e3", rvalid, 1'b1);
    check("rd_wait_e3", waitreq, 1'b0);
    if (exp_q.size() == 0) begin
      check("rd_queue", 0, 1);
    end else begin
      got_exp = exp_q.pop_front();
      check("rd_data", rdata, got_exp);
    end
    tick();
    check("rd_valid_e4", rvalid, 1'b0);
    check("rd_data_hold", rdata, e);
  endtask

  task automatic pulse_done(input bit w, input bit r);
    wr_done = w; rd_done = r;
    tick();
    wr_done = 1'b0; rd_done = 1'b0;
    if (w) m_wr_done = 1'b1;
    if (r) m_rd_done = 1'b1;
  endtask

  task automatic new_inputs();
    dout_first = {$urandom, $urandom};
    dout_last  = {$urandom, $urandom};
    din_first  = {$urandom, $urandom};
    din_last   = {$urandom, $urandom};
    chk_sts    = 4'($urandom_range(0, 15));
    link_sts   = 4'($urandom_range(0, 15));
    tick(); tick(); tick();
  endtask

  logic [31:0] addr_tab [20] = '{
    32'h5000_1000, 32'h5000_1004, 32'h5000_1008, 32'h5000_100C, 32'h5000_1010,
    32'h5000_2000, 32'h5000_2004, 32'h5000_2008, 32'h5000_4000, 32'h5000_4004,
    32'h5000_4010, 32'h5000_4014, 32'h5000_4020, 32'h5000_4024, 32'h5000_4030,
    32'h5000_4034, 32'h5000_4038, 32'h6000_1004, 32'h5000_3000, 32'h5001_2000
  };

  // ---------------- test sequence ----------------
  initial begin
    int v0;
    logic [31:0] d;

    // Reset defaults
    apply_reset();
    check("rst_readdata", rdata, 32'h0);
    check("rst_valid", rvalid, 1'b0);
    check("rst_wait", waitreq, 1'b0);
    check("rst_wr_go", wr_go, 1'b0);
    check("rst_rd_go", rd_go, 1'b0);
    check("rst_state", rd_state, 2'd0);
    check_regs("rst");
    do_read(32'h5000_2008);
    do_read(32'h5000_2000);
    do_read(32'h5000_2004);

    // RW and hold length
    do_write(32'h5000_2000, 32'hC, 3, 1'b0);
    do_read(32'h5000_2000);
    do_write(32'h5000_2004, 32'h20, 1, 1'b0);
    do_read(32'h5000_2004);
    do_write(32'h5000_1000, 32'h0000_0004, 4, 1'b0);

    // Start pulses and stickies
    pulse_done(1'b1, 1'b1);
    do_read(32'h5000_1008);
    do_write(32'h5000_1000, 32'h0004_1804, 1, 1'b0);
    check("wr_cfg_masked", wr_cfg, 32'h0004_1800);
    do_read(32'h5000_1008);
    pulse_done(1'b1, 1'b0);
    do_read(32'h5000_1008);
    do_write(32'h5000_1010, 32'h0000_0004, 2, 1'b0);
    pulse_done(1'b0, 1'b1);
    do_read(32'h5000_1008);
    do_read(32'h5000_1010);

    // 64-bit capture
    din_last = 64'h0123_4567_89AB_CDEF;
    tick();
    do_read(32'h5000_4030);
    do_read(32'h5000_4034);
    do_read(32'h5000_4038);

    // Link status and unmapped
    link_sts = 4'hF;
    tick(); tick(); tick();
    do_read(32'h5000_100C);
    do_write(32'h5000_1004, 32'h1234_5678, 1, 1'b0);
    do_read(32'h6000_1004);
    do_write(32'h6000_1004, 32'hDEAD_BEEF, 1, 1'b0);
    do_write(32'h5000_1008, 32'hFFFF_FFFF, 1, 1'b0);
    do_read(32'h5000_1004);

    // Simultaneous edges: write executes, read dropped
    v0 = valid_cnt;
    addr = 32'h5000_2008; wdata = 32'h55; wren = 1'b1; rden = 1'b1;
    tick();
    wren = 1'b0; rden = 1'b0;
    check("coll_wait", waitreq, 1'b0);
    tick(); tick(); tick(); tick();
    model_write(32'h5000_2008, 32'h55);
    check("coll_no_valid", valid_cnt, v0);
    check_regs("coll");

    // Read edge while a read is in flight is ignored
    v0 = valid_cnt;
    exp_q.push_back(exp_read(32'h5000_1004));
    addr = 32'h5000_1004; rden = 1'b1;
    tick();
    rden = 1'b0;
    tick();
    addr = 32'h5000_2008; rden = 1'b1;
    tick();
    check("busy_valid", rvalid, 1'b1);
    check("busy_data", rdata, exp_q.pop_front());
    tick();
    rden = 1'b0;
    tick(); tick(); tick();
    check("busy_one_pulse", valid_cnt, v0 + 1);
    check("busy_idle", rd_state, 2'd0);

    // Completion pulse coinciding with the go-write keeps the sticky set
    do_write(32'h5000_1000, 32'h0000_0004, 1, 1'b1);
    do_read(32'h5000_1008);
    check("sticky_set_wins", m_wr_done, 1'b1);

    // Reset during DECODE
    v0 = valid_cnt;
    addr = 32'h5000_2000; rden = 1'b1;
    tick();
    check("mid_state_decode", rd_state, 2'd1);
    rden = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wait", waitreq, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    model_reset();
    check("mid_rst_no_valid", valid_cnt, v0);
    check("mid_rst_data", rdata, 32'h0);
    check_regs("mid_rst");

    // Randomized phase
    new_inputs();
    for (int i = 0; i < 80; i++) begin
      int pick;
      logic [31:0] a;
      pick = $urandom_range(0, 9);
      a = addr_tab[$urandom_range(0, 19)];
      if (pick <= 3) begin
        d = $urandom;
        do_write(a, d, $urandom_range(1, 4), ($urandom_range(0, 3) == 0));
      end else if (pick <= 7) begin
        do_read(a);
      end else if (pick == 8) begin
        pulse_done(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        new_inputs();
      end
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aximm_csr_slave.md
# aximm_csr_slave

Memory-mapped CSR responder for the AXI-MM-over-AIB test harness. It is the slave end of the host control bus (`i_wren`/`i_rden`/`i_wr_addr`/`i_wrdata` in; `o_master_readdata`/`o_master_readdatavalid`/`o_master_waitrequest` out). It decodes accesses into configuration, delay, status and data-capture registers, and issues single-cycle start pulses to the AXI-MM write and read traffic generators. It sits between the host port of `aximm_aib_top` and the leader-side generator/checker logic.

## Interface
**Parameters**
- `BASE_HI`, default 16'h5000: required value of address bits [31:16]; any other value is unmapped.
- `DLY_X_RST`, default 32'h0: reset value of DELAY_X.
- `DLY_Y_RST`, default 32'h0: reset value of DELAY_Y.
- `DLY_Z_RST`, default 32'h0: reset value of DELAY_Z.

**Ports**
- `avmm_clk` in 1: the single clock for the block.
- `avmm_rst_n` in 1: reset, asynchronous, active-low.
- `i_wren` in 1: write request, level; may be held for several cycles.
- `i_rden` in 1: read request, level; may be held for several cycles.
- `i_wr_addr` in 32: byte address, shared by reads and writes.
- `i_wrdata` in 32: write data.
- `o_master_readdata` out 32: read data.
- `o_master_readdatavalid` out 1: one-cycle pulse that qualifies `o_master_readdata`.
- `o_master_waitrequest` out 1: high while a read is in flight.
- `i_link_sts` in 4: {sl_rx_online, sl_tx_online, ms_rx_online, ms_tx_online}, asynchronous.
- `i_chk_sts` in 4: checker flags; [3:2] = align ok, [1] = compare done, [0] = compare pass.
- `i_wr_done`, `i_rd_done` in 1: one-cycle completion pulses from the generator.
- `i_dout_first`, `i_dout_last`, `i_din_first`, `i_din_last` in 64 each: captured data beats.
- `o_wr_cfg`, `o_rd_cfg`, `o_mm_addr` out 32 each: register contents. Bit 2 of each cfg output always reads 0.
- `o_wr_go`, `o_rd_go` out 1: one-cycle start pulses.
- `o_dly_x`, `o_dly_y`, `o_dly_z` out 32 each.

## Operation
- **Access detect.** Registered copies of `i_wren` and `i_rden` are kept. An access fires on a 0→1 edge only, so there is exactly one access per assertion however long the request is held.
- **Simultaneous edges.** If both edges occur in the same cycle, only the write executes. The read is dropped and no readdatavalid pulse follows.
- **Address map** (offset = `i_wr_addr[15:0]`; `i_wr_addr[31:16]` must equal `BASE_HI`):
  - 0x1000 WR_CFG (RW). Writing bit 2 = 1 pulses `o_wr_go` and clears the WR_DONE sticky. Bit 2 is never stored.
  - 0x1004 MM_ADDR (RW).
  - 0x1008 BUS_STS (RO): {26'b0, RD_DONE, WR_DONE, i_chk_sts}.
  - 0x100C LINKUP_STS (RO): {28'b0, synchronised i_link_sts}.
  - 0x1010 RD_CFG (RW). Same rules as WR_CFG, using `o_rd_go` and RD_DONE.
  - 0x2000, 0x2004, 0x2008: DELAY_X, DELAY_Y, DELAY_Z (RW).
  - 0x4000/0x4004: `i_dout_first` [31:0]/[63:32] (RO).
  - 0x4010/0x4014: `i_dout_last` [31:0]/[63:32] (RO).
  - 0x4020/0x4024: `i_din_first` [31:0]/[63:32] (RO).
  - 0x4030/0x4034: `i_din_last` [31:0]/[63:32] (RO).
- **Unmapped or read-only targets.** Writes to them are ignored. Reads of unmapped addresses return 32'h0.
- **Sticky bits.** WR_DONE is set by `i_wr_done` and RD_DONE by `i_rd_done`. Each clears only on its own go-write. If set and clear occur in the same cycle, set wins.
- **Link status.** `i_link_sts` passes through a 2-flop synchroniser before it is readable.
- **Read FSM.** States IDLE → DECODE → RESP → IDLE.
  - Read edge in IDLE: latch the address, go to DECODE, assert waitrequest.
  - DECODE: register the mux output.
  - RESP: drive readdatavalid = 1 with data, deassert waitrequest.
  - A read edge outside IDLE is ignored.
  - A write edge in any state executes immediately.

## Timing
- **Reset values.**
  - All RW registers are 0, except DELAY_X/Y/Z, which take `DLY_*_RST`.
  - Sticky bits and synchroniser flops are 0.
  - `o_master_readdata` = 0; `o_master_readdatavalid`, `o_master_waitrequest`, `o_wr_go` and `o_rd_go` are all 0.
  - The FSM is in IDLE.
- **Write.** Let E be the cycle in which the registered request first differs from the input. The register updates at the end of cycle E+1, so the new value is visible on outputs in E+2. `o_*_go` is high during E+2 for exactly one cycle.
- **Read.**
  - `o_master_waitrequest` is high in cycles E+1 and E+2.
  - `o_master_readdatavalid` is high in E+3 for exactly one cycle; readdata is valid in the same cycle.
  - `o_master_readdata` holds its value until the next response.
- **Reset mid-read.** Any in-flight read is abandoned and no valid pulse is produced.
- **Read of status.** Returns the value present in the DECODE cycle.

## Test plan
- **Reset defaults.** Reset, then read 0x50002008 → 0 with `DLY_Z_RST`=0. Set `DLY_Z_RST`=32'h1770, reset, read → 0x1770. Valid pulse exactly 3 cycles after the rden edge.
- **RW and hold-length.** Write 0x50002000=0xC with wren held 3 cycles → exactly one write. Read back 0xC. Write 0x50002004=0x20, read back 0x20.
- **Start pulse and stickies.** Write 0x50001000=0x00041804 → `o_wr_go` high for 1 cycle; `o_wr_cfg`=0x00041800; WR_DONE cleared. Pulse `i_wr_done` → BUS_STS[4]=1. Repeat on RD_CFG → `o_rd_go`, BUS_STS[5]=1.
- **64-bit capture.** `i_din_last`=64'h0123456789ABCDEF → 0x50004030 reads 0x89ABCDEF and 0x50004034 reads 0x01234567. 0x50004038 reads 0.
- **Link and unmapped.** `i_link_sts`=4'hF → 0x5000100C reads 0xF. 0x60001004 reads 0, and a write to it leaves MM_ADDR unchanged.
- **Collisions.**
  - Simultaneous wren/rden edges → write done, no valid pulse.
  - Second rden edge during DECODE → ignored.
  - `i_wr_done` in the same cycle as a go-write → WR_DONE=1.
  - Reset asserted in DECODE → no valid pulse and waitrequest=0.
